gearbox_22_lock: RTL and testbench
==================================

# gearbox_22_lock

Word-alignment controller for the 20-to-22-bit gearbox. It watches the 2-bit sync header at the bottom of each 22-bit gearbox output word and steps the gearbox through all 22 bit alignments using its `odd` (1-bit shift) and `drop2` (2-bit slip) controls until headers are consistently legal. Once aligned it declares lock, then polices the header error rate and drops lock when the rate is too high. It sits beside the gearbox in the receive path, between the deserializer and the descrambler/framer.

## Interface
Parameters:
- `LOCK_CNT`, 64: consecutive good headers required in HUNT to reach LOCKED (2..1023).
- `ERR_WINDOW`, 64: number of valid headers per error-monitoring window in LOCKED (2..1023).
- `ERR_LIMIT`, 16: bad headers within one window that force loss of lock (1..`ERR_WINDOW`).
- `SLIP_WAIT`, 4: valid headers ignored after each slip while the gearbox pipeline flushes (1..15).

Ports:
- `clk`, in, 1: single clock, shared with the gearbox.
- `arst_n`, in, 1: asynchronous, active-low reset.
- `hdr`, in, 2: gearbox `dout[1:0]`. Bit 0 is the first received bit.
- `hdr_valid`, in, 1: gearbox `dout_valid`.
- `relock`, in, 1: synchronous pulse that forces a restart of alignment.
- `odd`, out, 1: drives the gearbox `odd` input. Registered.
- `drop2`, out, 1: drives the gearbox `drop2` input. Registered, at most one cycle high per slip.
- `locked`, out, 1: high while in LOCKED.
- `align_pos`, out, 5: current alignment index, 0..21. Always equals 2·k + `odd` mod 22.
- `slip_pulse`, out, 1: one-cycle status strobe, high on each completed slip.

## Operation
- A header is good when `hdr` is 2'b01 or 2'b10. It is bad when `hdr` is 2'b00 or 2'b11.
- A header is counted only in cycles with `hdr_valid` high.
- **HUNT**
  - Each good header increments `good_cnt`.
  - When `good_cnt` reaches `LOCK_CNT`, go to LOCKED and clear all counters.
  - Any bad header goes to SLIP.
- **SLIP** (advances alignment by exactly 1 bit)
  - If `odd` is 0: set `odd` to 1. No `drop2`. This completes in the SLIP cycle.
  - If `odd` is 1: clear `odd` and pulse `drop2`. The `drop2` pulse is issued only in the cycle after a cycle in which `hdr_valid` was sampled low. This keeps the pulse clear of the gearbox state wrap, where `drop2` would be ignored. SLIP waits as long as needed for that opportunity, at most 12 cycles. `odd` and `drop2` change in the same cycle.
  - `align_pos` increments mod 22, so 21 goes to 0. `slip_pulse` is asserted in the completing cycle.
  - Then go to WAIT.
- **WAIT**
  - Discard `SLIP_WAIT` valid headers without checking them.
  - Then go to HUNT with `good_cnt` cleared.
- **LOCKED**
  - `win_cnt` counts valid headers. `bad_cnt` counts bad valid headers.
  - If `bad_cnt` reaches `ERR_LIMIT` before the window closes: clear `locked` and go directly to SLIP.
  - When `win_cnt` reaches `ERR_WINDOW` with `bad_cnt` below `ERR_LIMIT`: clear both counters and stay in LOCKED.
  - If the last header of a window is the `ERR_LIMIT`-th bad one, loss of lock wins.
- **relock**
  - From any state, `relock` goes to HUNT with counters cleared and `locked` low.
  - `odd` and `align_pos` keep their values.
  - `relock` overrides any other transition in the same cycle.
  - If `relock` arrives during SLIP while waiting for a `drop2` opportunity, the slip is abandoned: no `drop2`, and `odd` and `align_pos` are unchanged.
- Counters saturate and never wrap. Counter widths are sized from their parameters.

## Timing
- Reset values, all asynchronous: state HUNT; `odd`=0, `drop2`=0, `locked`=0, `align_pos`=0, `slip_pulse`=0; all counters 0.
- Reset mid-slip abandons the slip.
- Header sample to state change: 1 cycle. All outputs are registered.
- A bad header in HUNT at cycle t with `odd`=0 gives `odd`=1 and `slip_pulse`=1 at t+2. HUNT to SLIP takes one cycle, and SLIP completes in its first cycle.
- `locked` rises in the cycle after the `LOCK_CNT`-th good header is sampled.
- `locked` falls in the cycle after the `ERR_LIMIT`-th bad header is sampled.
- Headers sampled in a slip-completion cycle are not counted.
- Worst-case time to scan all 22 alignments: 22 × (12 + `SLIP_WAIT`×11/10 + 2) cycles, plus hunting time.

## Test plan
- **Async reset:** pull `arst_n` low mid-LOCKED with no clock edge. Required: `locked`, `odd`, `drop2`, `align_pos` all 0 immediately.
- **Already aligned:** feed `hdr`=01 on all valid cycles after reset. Required: `locked`=1 after the 64th valid header; `slip_pulse` never asserted; `align_pos`=0.
- **Odd slip and drop2 slip:**
  - One bad header in HUNT with `odd`=0. Required: `odd`=1, `align_pos`=1, no `drop2`.
  - A further bad header after WAIT. Required: `drop2` high for exactly 1 cycle, in the cycle after the next `hdr_valid`=0 sample; `odd`=0 in that same cycle; `align_pos`=2.
- **Error window threshold:** in LOCKED, 15 bad headers in a 64-header window. Required: stays locked and counters clear at the window end. Next window with 16 bad headers. Required: `locked` falls in the cycle after the 16th, followed by a slip.
- **Wrap:** force 22 consecutive slips with a bench-model gearbox and random data. Required: `align_pos` sequence 1..21, then 0, with `odd` alternating; 11 `drop2` pulses, each accepted by the model (its state never at 0xA when sampled).
- **Relock during drop2 wait:** pulse `relock` in SLIP with `odd`=1 before the `hdr_valid`=0 opportunity. Required: no `drop2`; `odd`=1 and `align_pos` unchanged; state HUNT.

Source files
------------

// File: rtl/gearbox_22_lock_if.sv
// Header/control bundle between the 22-bit gearbox and its alignment controller.
// The slave side is the lock controller; the master side is the gearbox/receiver.
interface gearbox_22_lock_if;
  logic [1:0] hdr;
  logic       hdr_valid;
  logic       relock;
  logic       odd;
  logic       drop2;
  logic       locked;
  logic [4:0] align_pos;
  logic       slip_pulse;

  modport master (
    output hdr, hdr_valid, relock,
    input  odd, drop2, locked, align_pos, slip_pulse
  );

  modport slave (
    input  hdr, hdr_valid, relock,
    output odd, drop2, locked, align_pos, slip_pulse
  );
endinterface

// File: rtl/gearbox_22_lock.sv
// Sync-header word aligner for the 20-to-22 gearbox: hunts over 22 bit
// positions with odd/drop2, declares lock, and polices the header error rate.
module gearbox_22_lock #(
  parameter int LOCK_CNT   = 64,
  parameter int ERR_WINDOW = 64,
  parameter int ERR_LIMIT  = 16,
  parameter int SLIP_WAIT  = 4
) (
  input logic              clk,
  input logic              arst_n,
  gearbox_22_lock_if.slave bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int BW = $clog2(ERR_LIMIT + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(ERR_LIMIT - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    WAIT,
    LOCKED
  } state_t;

  state_t        state, state_d;
  logic          odd_q, odd_d;
  logic          drop2_q, drop2_d;
  logic          locked_q, locked_d;
  logic          slip_q, slip_d;
  logic [4:0]    pos_q, pos_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_q, win_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [SW-1:0] wait_q, wait_d;

  logic       good_hdr;
  logic [4:0] pos_inc;

  assign good_hdr = bus.hdr[0] ^ bus.hdr[1];
  assign pos_inc  = (pos_q == 5'd21) ? 5'd0 : pos_q + 5'd1;

  assign bus.odd        = odd_q;
  assign bus.drop2      = drop2_q;
  assign bus.locked     = locked_q;
  assign bus.align_pos  = pos_q;
  assign bus.slip_pulse = slip_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= HUNT;
      odd_q    <= 1'b0;
      drop2_q  <= 1'b0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
      pos_q    <= 5'd0;
      good_q   <= '0;
      win_q    <= '0;
      bad_q    <= '0;
      wait_q   <= '0;
    end else begin
      state    <= state_d;
      odd_q    <= odd_d;
      drop2_q  <= drop2_d;
      locked_q <= locked_d;
      slip_q   <= slip_d;
      pos_q    <= pos_d;
      good_q   <= good_d;
      win_q    <= win_d;
      bad_q    <= bad_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state;
    odd_d    = odd_q;
    drop2_d  = 1'b0;
    locked_d = locked_q;
    slip_d   = 1'b0;
    pos_d    = pos_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    wait_d   = wait_q;

    if (bus.relock) begin
      state_d  = HUNT;
      locked_d = 1'b0;
      good_d   = '0;
      win_d    = '0;
      bad_d    = '0;
      wait_d   = '0;
    end else begin
      unique case (state)
        HUNT: begin
          if (bus.hdr_valid) begin
            if (!good_hdr) begin
              state_d = SLIP;
              good_d  = '0;
            end else if (good_q == GOOD_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              good_d   = '0;
              win_d    = '0;
              bad_d    = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end
        end
        SLIP: begin
          // drop2 only lands right after a gap, clear of the gearbox wrap
          if (!odd_q || !bus.hdr_valid) begin
            odd_d   = ~odd_q;
            drop2_d = odd_q;
            pos_d   = pos_inc;
            slip_d  = 1'b1;
            wait_d  = '0;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (bus.hdr_valid && !slip_q) begin
            if (wait_q == WAIT_LAST) begin
              state_d = HUNT;
              wait_d  = '0;
              good_d  = '0;
            end else begin
              wait_d = wait_q + SW'(1);
            end
          end
        end
        LOCKED: begin
          if (bus.hdr_valid) begin
            if (!good_hdr && bad_q == BAD_LAST) begin
              state_d  = SLIP;
              locked_d = 1'b0;
              win_d    = '0;
              bad_d    = '0;
            end else if (win_q == WIN_LAST) begin
              win_d = '0;
              bad_d = '0;
            end else begin
              win_d = win_q + WW'(1);
              if (!good_hdr) bad_d = bad_q + BW'(1);
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gearbox_22_lock.sv
// Randomized scenario bench for gearbox_22_lock, with a small gearbox timing
// model (11-state cycle, one idle output every 11 cycles).
module tb_gearbox_22_lock;
  localparam int LOCK_CNT   = 64;
  localparam int ERR_WINDOW = 64;
  localparam int ERR_LIMIT  = 16;
  localparam int SLIP_WAIT  = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   gb_st = 0;

  gearbox_22_lock_if bus ();

  gearbox_22_lock #(
    .LOCK_CNT  (LOCK_CNT),
    .ERR_WINDOW(ERR_WINDOW),
    .ERR_LIMIT (ERR_LIMIT),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] rgood();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rbad();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    gb_st = (gb_st == 10) ? 0 : gb_st + 1;
  endtask

  task automatic drv(input logic [1:0] h, input logic v);
    bus.hdr = h;
    bus.hdr_valid = v;
  endtask

  task automatic do_reset();
    drv(2'b00, 1'b0);
    bus.relock = 1'b0;
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    gb_st = 0;
  endtask

  // Good headers on gearbox-valid cycles; lock must rise right after the
  // LOCK_CNT-th valid one.
  task automatic feed_lock(input string tag);
    int n;
    logic v;
    n = 0;
    for (int c = 0; c < 400 && bus.locked !== 1'b1; c++) begin
      v = (gb_st != 0);
      drv(v ? rgood() : 2'($urandom), v);
      tick();
      if (v) n++;
      checks++;
      if (bus.locked !== (n >= LOCK_CNT)) begin
        failures++;
        $display("FAIL %s_locked n=%0d got=%0b", tag, n, bus.locked);
      end
    end
    checks++;
    if (n !== LOCK_CNT) begin
      failures++;
      $display("FAIL %s_lock_count got=%0d exp=%0d", tag, n, LOCK_CNT);
    end
  endtask

  task automatic test_reset();
    drv(2'b01, 1'b1);
    bus.relock = 1'b0;
    #3;
    arst_n = 1'b0;
    #1;
    checks++;
    if (bus.locked !== 1'b0) begin
      failures++;
      $display("FAIL rst_locked got=%0b exp=0", bus.locked);
    end
    checks++;
    if (bus.odd !== 1'b0) begin
      failures++;
      $display("FAIL rst_odd got=%0b exp=0", bus.odd);
    end
    checks++;
    if (bus.drop2 !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop2 got=%0b exp=0", bus.drop2);
    end
    checks++;
    if (bus.align_pos !== 5'd0) begin
      failures++;
      $display("FAIL rst_pos got=%0d exp=0", bus.align_pos);
    end
    checks++;
    if (bus.slip_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rst_slip got=%0b exp=0", bus.slip_pulse);
    end
    tick();
    tick();
    arst_n = 1'b1;
    gb_st = 0;
  endtask

  task automatic test_aligned();
    int n;
    logic v;
    do_reset();
    n = 0;
    for (int c = 0; c < 1000 && n < LOCK_CNT + 8; c++) begin
      v = ($urandom_range(0, 3) != 0);
      drv(v ? 2'b01 : 2'($urandom), v);
      tick();
      if (v) n++;
      checks++;
      if (bus.locked !== (n >= LOCK_CNT)) begin
        failures++;
        $display("FAIL aligned_locked n=%0d got=%0b", n, bus.locked);
      end
      checks++;
      if (bus.slip_pulse !== 1'b0) begin
        failures++;
        $display("FAIL aligned_slip n=%0d got=1 exp=0", n);
      end
    end
    checks++;
    if (bus.align_pos !== 5'd0) begin
      failures++;
      $display("FAIL aligned_pos got=%0d exp=0", bus.align_pos);
    end
  endtask

  task automatic test_slips();
    int r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(rgood(), 1'b1);
      tick();
    end
    drv(rbad(), 1'b1);
    tick();
    checks++;
    if (bus.odd !== 1'b0 || bus.slip_pulse !== 1'b0) begin
      failures++;
      $display("FAIL slip1_early odd=%0b slip=%0b exp=0/0",
               bus.odd, bus.slip_pulse);
    end
    drv(rgood(), 1'b1);
    tick();
    checks++;
    if (bus.odd !== 1'b1 || bus.slip_pulse !== 1'b1) begin
      failures++;
      $display("FAIL slip1_done odd=%0b slip=%0b exp=1/1",
               bus.odd, bus.slip_pulse);
    end
    checks++;
    if (bus.align_pos !== 5'd1 || bus.drop2 !== 1'b0) begin
      failures++;
      $display("FAIL slip1_pos pos=%0d drop2=%0b exp=1/0",
               bus.align_pos, bus.drop2);
    end
    // bad headers in the completion cycle and during WAIT are ignored
    for (int i = 0; i < SLIP_WAIT + 1; i++) begin
      drv(rbad(), 1'b1);
      tick();
      checks++;
      if (bus.slip_pulse !== 1'b0 || bus.odd !== 1'b1) begin
        failures++;
        $display("FAIL wait_ignore i=%0d slip=%0b odd=%0b exp=0/1",
                 i, bus.slip_pulse, bus.odd);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drv(rgood(), (i % 3) != 0);
      tick();
      checks++;
      if (bus.slip_pulse !== 1'b0 || bus.drop2 !== 1'b0) begin
        failures++;
        $display("FAIL hunt_quiet i=%0d slip=%0b drop2=%0b exp=0/0",
                 i, bus.slip_pulse, bus.drop2);
      end
    end
    drv(rbad(), 1'b1);
    tick();
    r = $urandom_range(0, 5);
    for (int i = 0; i < r; i++) begin
      drv(rgood(), 1'b1);
      tick();
      checks++;
      if (bus.drop2 !== 1'b0 || bus.odd !== 1'b1 ||
          bus.align_pos !== 5'd1) begin
        failures++;
        $display("FAIL slip2_wait drop2=%0b odd=%0b pos=%0d exp=0/1/1",
                 bus.drop2, bus.odd, bus.align_pos);
      end
    end
    drv(2'($urandom), 1'b0);
    tick();
    checks++;
    if (bus.drop2 !== 1'b1 || bus.odd !== 1'b0) begin
      failures++;
      $display("FAIL slip2_drop2 drop2=%0b odd=%0b exp=1/0",
               bus.drop2, bus.odd);
    end
    checks++;
    if (bus.align_pos !== 5'd2 || bus.slip_pulse !== 1'b1) begin
      failures++;
      $display("FAIL slip2_pos pos=%0d slip=%0b exp=2/1",
               bus.align_pos, bus.slip_pulse);
    end
    drv(rgood(), 1'b1);
    tick();
    checks++;
    if (bus.drop2 !== 1'b0) begin
      failures++;
      $display("FAIL slip2_width drop2=%0b exp=0", bus.drop2);
    end
  endtask

  task automatic run_window(input int nbad, input bit last_bad,
                            output int lost_at);
    bit   bad_at[ERR_WINDOW];
    int   k, hi, p, idx, bads;
    logic v, b;
    foreach (bad_at[i]) bad_at[i] = 1'b0;
    k = 0;
    if (last_bad) begin
      bad_at[ERR_WINDOW-1] = 1'b1;
      k = 1;
    end
    hi = last_bad ? ERR_WINDOW - 2 : ERR_WINDOW - 1;
    while (k < nbad) begin
      p = $urandom_range(0, hi);
      if (!bad_at[p]) begin
        bad_at[p] = 1'b1;
        k++;
      end
    end
    idx = 0;
    bads = 0;
    lost_at = 0;
    for (int c = 0; c < 400 && idx < ERR_WINDOW && lost_at == 0; c++) begin
      v = (gb_st != 0);
      b = v && bad_at[idx];
      drv(v ? (b ? rbad() : rgood()) : 2'($urandom), v);
      tick();
      if (v) begin
        idx++;
        if (b) bads++;
      end
      checks++;
      if (bus.locked !== (bads < ERR_LIMIT)) begin
        failures++;
        $display("FAIL win_locked idx=%0d bads=%0d got=%0b",
                 idx, bads, bus.locked);
      end
      if (bads >= ERR_LIMIT) lost_at = idx;
    end
  endtask

  task automatic test_window();
    int l;
    do_reset();
    feed_lock("win_lock");
    run_window(ERR_LIMIT - 1, 1'b0, l);
    checks++;
    if (l !== 0) begin
      failures++;
      $display("FAIL win1_kept lost_at=%0d exp=0", l);
    end
    run_window(ERR_LIMIT - 1, 1'b1, l);
    checks++;
    if (l !== 0) begin
      failures++;
      $display("FAIL win2_kept lost_at=%0d exp=0", l);
    end
    run_window(ERR_LIMIT, 1'b0, l);
    checks++;
    if (l == 0) begin
      failures++;
      $display("FAIL win3_lost lost_at=0 exp=nonzero");
    end
    drv(rgood(), gb_st != 0);
    tick();
    checks++;
    if (bus.slip_pulse !== 1'b1 || bus.odd !== 1'b1 ||
        bus.align_pos !== 5'd1) begin
      failures++;
      $display("FAIL win3_slip slip=%0b odd=%0b pos=%0d exp=1/1/1",
               bus.slip_pulse, bus.odd, bus.align_pos);
    end
    drv(rgood(), gb_st != 0);
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
    checks++;
    if (bus.locked !== 1'b0) begin
      failures++;
      $display("FAIL win_relock locked=%0b exp=0", bus.locked);
    end
    feed_lock("win_relock");
    run_window(ERR_LIMIT, 1'b1, l);
    checks++;
    if (l !== ERR_WINDOW) begin
      failures++;
      $display("FAIL win_last_lost lost_at=%0d exp=%0d", l, ERR_WINDOW);
    end
  endtask

  task automatic test_relock();
    do_reset();
    drv(rbad(), 1'b1);
    tick();
    drv(rgood(), 1'b1);
    tick();
    for (int i = 0; i < SLIP_WAIT + 4; i++) begin
      drv(rgood(), 1'b1);
      tick();
    end
    drv(rbad(), 1'b1);
    tick();
    drv(rgood(), 1'b1);
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
    checks++;
    if (bus.drop2 !== 1'b0 || bus.slip_pulse !== 1'b0) begin
      failures++;
      $display("FAIL relock_noslip drop2=%0b slip=%0b exp=0/0",
               bus.drop2, bus.slip_pulse);
    end
    checks++;
    if (bus.odd !== 1'b1 || bus.align_pos !== 5'd1) begin
      failures++;
      $display("FAIL relock_keep odd=%0b pos=%0d exp=1/1",
               bus.odd, bus.align_pos);
    end
    for (int i = 0; i < 3; i++) begin
      drv(2'($urandom), 1'b0);
      tick();
      checks++;
      if (bus.drop2 !== 1'b0) begin
        failures++;
        $display("FAIL relock_nodrop i=%0d drop2=1 exp=0", i);
      end
    end
    gb_st = 1;
    feed_lock("relock_hunt");
    checks++;
    if (bus.odd !== 1'b1 || bus.align_pos !== 5'd1) begin
      failures++;
      $display("FAIL relock_final odd=%0b pos=%0d exp=1/1",
               bus.odd, bus.align_pos);
    end
  endtask

  task automatic test_async_reset();
    checks++;
    if (bus.locked !== 1'b1) begin
      failures++;
      $display("FAIL ares_pre locked=%0b exp=1", bus.locked);
    end
    #3;
    arst_n = 1'b0;
    #1;
    checks++;
    if (bus.locked !== 1'b0 || bus.odd !== 1'b0) begin
      failures++;
      $display("FAIL ares_lo locked=%0b odd=%0b exp=0/0",
               bus.locked, bus.odd);
    end
    checks++;
    if (bus.drop2 !== 1'b0 || bus.align_pos !== 5'd0) begin
      failures++;
      $display("FAIL ares_pos drop2=%0b pos=%0d exp=0/0",
               bus.drop2, bus.align_pos);
    end
    tick();
    arst_n = 1'b1;
    gb_st = 0;
  endtask

  task automatic test_wrap();
    int   slips, drops;
    logic pv;
    do_reset();
    slips = 0;
    drops = 0;
    for (int c = 0; c < 4000 && slips < 22; c++) begin
      pv = (gb_st != 0);
      drv(2'($urandom), pv);
      tick();
      if (bus.drop2 === 1'b1) begin
        drops++;
        checks++;
        if (gb_st == 10 || pv !== 1'b0) begin
          failures++;
          $display("FAIL wrap_drop2_ok gb_st=%0d prev_valid=%0b", gb_st, pv);
        end
      end
      if (bus.slip_pulse === 1'b1) begin
        slips++;
        checks++;
        if (bus.align_pos !== 5'(slips % 22) ||
            bus.odd !== 1'(slips % 2) ||
            bus.drop2 !== ((slips % 2) == 0)) begin
          failures++;
          $display("FAIL wrap_step n=%0d pos=%0d odd=%0b drop2=%0b",
                   slips, bus.align_pos, bus.odd, bus.drop2);
        end
      end else begin
        checks++;
        if (bus.drop2 !== 1'b0) begin
          failures++;
          $display("FAIL wrap_stray_drop2 got=1 exp=0");
        end
      end
    end
    checks++;
    if (slips !== 22 || drops !== 11) begin
      failures++;
      $display("FAIL wrap_count slips=%0d drops=%0d exp=22/11", slips, drops);
    end
    checks++;
    if (bus.align_pos !== 5'd0 || bus.odd !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end pos=%0d odd=%0b exp=0/0",
               bus.align_pos, bus.odd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hdr = 2'b00;
    bus.hdr_valid = 1'b0;
    bus.relock = 1'b0;
    test_reset();
    test_aligned();
    test_slips();
    test_window();
    test_relock();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
